csr_init_seq: RTL and testbench

CSR_INIT_SEQ -- requirements
Module: csr_init_seq

---
 rtl/csr_init_seq.sv | 164 ++++++++++++++++
 tb/tb_csr_init_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_init_seq.sv
// Boot-time CSR initialisation sequencer: replays a parameterised table of
// WRITE/WAIT/POLL/END entries on the CSR bus, then hands the bus to the master.
module csr_init_seq #(
    parameter int unsigned                   NUM_ENTRIES  = 4,
    parameter logic [16*NUM_ENTRIES-1:0]     INIT_TABLE   = 64'h0,
    parameter int unsigned                   POLL_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [4:0] m_csr_a,
    input  logic [7:0] m_csr_do,
    input  logic       m_csr_we,
    output logic [7:0] m_csr_di,
    output logic [4:0] csr_a,
    output logic [7:0] csr_do,
    output logic       csr_we,
    input  logic [7:0] csr_di,
    output logic       done,
    output logic       seq_err,
    output logic       m_drop
);
    localparam int unsigned AW          = 5;
    localparam int unsigned DW          = 8;
    localparam int unsigned EW          = 16;
    localparam int unsigned MAX_ENTRIES = 32;
    localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_ENTRIES - 1);
    localparam logic [DW-1:0] TIMEOUT   = DW'(POLL_TIMEOUT);

    typedef enum logic {ST_SEQ, ST_DONE} state_t;
    typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_WAIT = 2'b01,
                              OP_POLL  = 2'b10, OP_END  = 2'b11} op_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          started_q;
    logic          first_q, first_d;
    logic          seq_err_q, seq_err_d;
    logic          m_drop_q, m_drop_d;

    logic [EW-1:0] tbl [MAX_ENTRIES];
    logic [EW-1:0] entry;
    op_t           op;
    logic [AW-1:0] ent_addr;
    logic [DW-1:0] ent_data;
    logic          unused_rsvd;

    logic [DW-1:0] remain;
    logic [DW-1:0] ticks;
    logic          match;
    logic          timeout;
    logic          complete;

    // Slots past NUM_ENTRIES read as END; idx never reaches them
    for (genvar k = 0; k < MAX_ENTRIES; k++) begin : g_tbl
        if (k < NUM_ENTRIES) begin : g_used
            assign tbl[k] = INIT_TABLE[EW*k +: EW];
        end else begin : g_pad
            assign tbl[k] = 16'hC000;
        end
    end

    assign entry       = tbl[idx_q];
    assign op          = op_t'(entry[15:14]);
    assign ent_addr    = entry[12:8];
    assign ent_data    = entry[7:0];
    assign unused_rsvd = entry[13];

    assign seq_err = seq_err_q;
    assign m_drop  = m_drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SEQ;
            idx_q     <= '0;
            cnt_q     <= '0;
            started_q <= 1'b0;
            first_q   <= 1'b1;
            seq_err_q <= 1'b0;
            m_drop_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            started_q <= 1'b1;
            first_q   <= first_d;
            seq_err_q <= seq_err_d;
            m_drop_q  <= m_drop_d;
        end
    end

    // Entry execution / next state; the bus muxes between table and master
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        seq_err_d = seq_err_q;
        m_drop_d  = m_drop_q;
        csr_a     = '0;
        csr_do    = '0;
        csr_we    = 1'b0;
        m_csr_di  = '0;
        done      = 1'b0;
        remain    = '0;
        ticks     = '0;
        match     = 1'b0;
        timeout   = 1'b0;
        complete  = 1'b0;

        unique case (state_q)
            ST_SEQ: begin
                m_drop_d = m_drop_q | m_csr_we;
                if (started_q) begin
                    csr_a   = ent_addr;
                    csr_do  = ent_data;
                    first_d = 1'b0;
                    unique case (op)
                        OP_WRITE: begin
                            csr_we   = 1'b1;
                            complete = 1'b1;
                        end
                        OP_WAIT: begin
                            remain   = first_q ? ent_data : cnt_q;
                            complete = (remain == '0) || (tick && (remain == DW'(1)));
                            cnt_d    = remain - DW'(tick);
                        end
                        OP_POLL: begin
                            // First cycle only settles the address; ticks count from it
                            ticks    = (first_q ? {DW{1'b0}} : cnt_q) + DW'(tick);
                            match    = !first_q && ((csr_di & ent_data) == ent_data);
                            timeout  = (ticks >= TIMEOUT);
                            complete = match || timeout;
                            cnt_d    = ticks;
                            if (timeout && !match) begin
                                seq_err_d = 1'b1;
                            end
                        end
                        OP_END: begin
                            complete = 1'b1;
                        end
                    endcase
                    if (complete) begin
                        cnt_d   = '0;
                        first_d = 1'b1;
                        if ((op == OP_END) || (idx_q == LAST_IDX)) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d = idx_q + AW'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                csr_a    = m_csr_a;
                csr_do   = m_csr_do;
                csr_we   = m_csr_we;
                m_csr_di = csr_di;
            end
        endcase
    end
endmodule

// File: tb/tb_csr_init_seq.sv
// Randomised bench for csr_init_seq: two table configurations driven with
// shared random inputs and checked each cycle against an entry-level model.
`timescale 1ns/1ps
module tb_csr_init_seq;
    localparam int NA   = 10;
    localparam int NB   = 3;
    localparam int PT_A = 2;
    localparam int PT_B = 3;
    localparam logic [16*NA-1:0] TBL_A = {16'h1FAA, 16'hC3A5, 16'h1155, 16'h8700, 16'h8581,
                                          16'h9B04, 16'h4000, 16'h6003, 16'h0C80, 16'h1A3F};
    localparam logic [16*NB-1:0] TBL_B = {16'h0C80, 16'h4002, 16'h1A3F};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [4:0] m_a;
    logic [7:0] m_do;
    logic       m_we;
    logic [7:0] csr_di;

    logic [1:0][7:0] m_di_o;
    logic [1:0][4:0] csr_a_o;
    logic [1:0][7:0] csr_do_o;
    logic [1:0]      csr_we_o;
    logic [1:0]      done_o;
    logic [1:0]      err_o;
    logic [1:0]      drop_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, one slot per DUT
    logic [15:0] tbl [2][NA];
    int  n_ent [2];
    int  p_to  [2];
    int  m_idx [2];
    int  m_cyc [2];
    int  m_ticks [2];
    bit  m_started [2];
    bit  m_done [2];
    bit  m_err [2];
    bit  m_drop [2];

    int di_mode;
    int tick_pct;

    always #5 clk = ~clk;

    csr_init_seq #(.NUM_ENTRIES(NA), .INIT_TABLE(TBL_A), .POLL_TIMEOUT(PT_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .m_csr_a(m_a), .m_csr_do(m_do), .m_csr_we(m_we), .m_csr_di(m_di_o[0]),
        .csr_a(csr_a_o[0]), .csr_do(csr_do_o[0]), .csr_we(csr_we_o[0]), .csr_di(csr_di),
        .done(done_o[0]), .seq_err(err_o[0]), .m_drop(drop_o[0])
    );

    csr_init_seq #(.NUM_ENTRIES(NB), .INIT_TABLE(TBL_B), .POLL_TIMEOUT(PT_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .m_csr_a(m_a), .m_csr_do(m_do), .m_csr_we(m_we), .m_csr_di(m_di_o[1]),
        .csr_a(csr_a_o[1]), .csr_do(csr_do_o[1]), .csr_we(csr_we_o[1]), .csr_di(csr_di),
        .done(done_o[1]), .seq_err(err_o[1]), .m_drop(drop_o[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_idx[i]     = 0;
            m_cyc[i]     = 0;
            m_ticks[i]   = 0;
            m_started[i] = 1'b0;
            m_done[i]    = 1'b0;
            m_err[i]     = 1'b0;
            m_drop[i]    = 1'b0;
        end
    endtask

    task automatic drive_inputs();
        tick = ($urandom_range(0, 99) < tick_pct);
        m_we = ($urandom_range(0, 3) == 0);
        m_a  = 5'($urandom);
        m_do = 8'($urandom);
        case (di_mode)
            1:       csr_di = 8'h00;
            2:       csr_di = 8'hFF;
            default: csr_di = 8'($urandom);
        endcase
    endtask

    // Compare one DUT against the model for the current cycle, then advance the model
    task automatic eval_inst(input int i);
        logic [15:0] e;
        int  op, addr, dat, tt;
        bit  compl, match, to, err_set, in_seq;
        err_set = 1'b0;
        in_seq  = !m_done[i];
        check_eq("seq_err", 32'(err_o[i]), 32'(m_err[i]));
        check_eq("m_drop", 32'(drop_o[i]), 32'(m_drop[i]));
        if (m_done[i]) begin
            check_eq("done", 32'(done_o[i]), 32'd1);
            check_eq("pass_a", 32'(csr_a_o[i]), 32'(m_a));
            check_eq("pass_do", 32'(csr_do_o[i]), 32'(m_do));
            check_eq("pass_we", 32'(csr_we_o[i]), 32'(m_we));
            check_eq("pass_di", 32'(m_di_o[i]), 32'(csr_di));
        end else begin
            check_eq("done", 32'(done_o[i]), 32'd0);
            check_eq("m_di_zero", 32'(m_di_o[i]), 32'd0);
            if (!m_started[i]) begin
                check_eq("we_idle", 32'(csr_we_o[i]), 32'd0);
                m_started[i] = 1'b1;
            end else begin
                e    = tbl[i][m_idx[i]];
                op   = int'(e[15:14]);
                addr = int'(e[12:8]);
                dat  = int'(e[7:0]);
                check_eq("we", 32'(csr_we_o[i]), 32'(op == 0));
                if (op == 0 || op == 2) check_eq("addr", 32'(csr_a_o[i]), 32'(addr));
                if (op == 0) check_eq("wdata", 32'(csr_do_o[i]), 32'(dat));
                tt    = m_ticks[i] + int'(tick);
                match = 1'b0;
                to    = 1'b0;
                case (op)
                    0: compl = 1'b1;
                    1: compl = (dat == 0) || (tt >= dat);
                    2: begin
                        match = (m_cyc[i] >= 1) && ((int'(csr_di) & dat) == dat);
                        to    = (tt >= p_to[i]);
                        compl = match || to;
                        err_set = to && !match;
                    end
                    default: compl = 1'b1;
                endcase
                if (compl) begin
                    if (op == 3 || m_idx[i] == n_ent[i] - 1) begin
                        m_done[i] = 1'b1;
                    end else begin
                        m_idx[i]++;
                        m_cyc[i]   = 0;
                        m_ticks[i] = 0;
                    end
                end else begin
                    m_cyc[i]++;
                    m_ticks[i] = tt;
                end
            end
        end
        if (in_seq && m_we) m_drop[i] = 1'b1;
        if (err_set) m_err[i] = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_inputs();
        @(negedge clk);
        eval_inst(0);
        eval_inst(1);
    endtask

    // Asynchronous reset mid-cycle, check outputs immediately, release and replay
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_we", 32'(csr_we_o[i]), 32'd0);
            check_eq("rst_a", 32'(csr_a_o[i]), 32'd0);
            check_eq("rst_do", 32'(csr_do_o[i]), 32'd0);
            check_eq("rst_done", 32'(done_o[i]), 32'd0);
            check_eq("rst_err", 32'(err_o[i]), 32'd0);
            check_eq("rst_drop", 32'(drop_o[i]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive_inputs();
        @(negedge clk);
        eval_inst(0);
        eval_inst(1);
    endtask

    initial begin
        bit fired;
        rst_n    = 1'b0;
        tick     = 1'b0;
        m_a      = '0;
        m_do     = '0;
        m_we     = 1'b0;
        csr_di   = '0;
        di_mode  = 0;
        tick_pct = 30;
        n_ent[0] = NA;
        n_ent[1] = NB;
        p_to[0]  = PT_A;
        p_to[1]  = PT_B;
        for (int k = 0; k < NA; k++) tbl[0][k] = TBL_A[16*k +: 16];
        for (int k = 0; k < NB; k++) tbl[1][k] = TBL_B[16*k +: 16];
        for (int k = NB; k < NA; k++) tbl[1][k] = 16'hC000;
        model_reset();
        @(negedge clk);
        for (int r = 0; r < 12; r++) begin
            di_mode  = r % 4;
            tick_pct = 20 + 10 * (r % 5);
            apply_reset();
            fired = 1'b0;
            for (int c = 0; c < 120; c++) begin
                step();
                if (!fired && (((r % 3 == 1) && m_idx[0] == 2 && m_cyc[0] >= 1 && !m_done[0]) ||
                               ((r % 3 == 2) && m_done[0] && c >= 100))) begin
                    fired = 1'b1;
                    apply_reset();
                end
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
